cr_osf_ob_fifo: RTL

Output-stage buffer for the OSF path, directly downstream of the OSF debug controller. It stores data words under the controller's `fifo_hw_wr`/`fifo_hw_rd` strobes and returns `fifo_empty`/`fifo_full` to it. It also generates the `single_step_rd` grant that the controller uses in single-step debug mode, and keeps sticky overflow/underflow error flags.

---
 rtl/cr_osf_ob_fifo.sv | 100 ++++++++++
 1 files changed

// File: rtl/cr_osf_ob_fifo.sv
// OSF output-stage FIFO: show-ahead storage, sticky error flags and the single-step read grant.
// Optional macro CR_OSF_OB_FIFO_STATS_EN adds a high-water-mark output (fifo_hwm) and its clear input (stats_clr).
module cr_osf_ob_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        fifo_debug_mode,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              fifo_hw_wr,
  input  logic              fifo_hw_rd,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [AW:0]       fifo_used,
`ifdef CR_OSF_OB_FIFO_STATS_EN
  input  logic              stats_clr,
  output logic [AW:0]       fifo_hwm,
`endif
  input  logic              ss_step,
  output logic              single_step_rd,
  input  logic              err_clr,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam logic [1:0] MODE_SS = 2'd3;

  typedef enum logic [1:0] {SS_IDLE, SS_ARMED, SS_GRANT} ss_state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic              push_ok, pop_ok, empty_nxt, full_nxt;
  ss_state_t         ss_q, ss_nxt;

  // A pop on a full FIFO frees the slot, so a same-cycle push may use it.
  assign pop_ok    = fifo_hw_rd && !fifo_empty;
  assign push_ok   = fifo_hw_wr && (!fifo_full || pop_ok);
  assign wr_nxt    = wr_ptr + {{AW{1'b0}}, push_ok};
  assign rd_nxt    = rd_ptr + {{AW{1'b0}}, pop_ok};
  assign empty_nxt = (wr_nxt == rd_nxt);
  assign full_nxt  = (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_empty     <= 1'b1;
      fifo_full      <= 1'b0;
      fifo_used      <= '0;
      overflow_err   <= 1'b0;
      underflow_err  <= 1'b0;
      ss_q           <= SS_IDLE;
      single_step_rd <= 1'b0;
    end else begin
      wr_ptr         <= wr_nxt;
      rd_ptr         <= rd_nxt;
      fifo_empty     <= empty_nxt;
      fifo_full      <= full_nxt;
      fifo_used      <= wr_nxt - rd_nxt;
      ss_q           <= ss_nxt;
      single_step_rd <= (ss_nxt == SS_GRANT);
      if (err_clr) begin
        overflow_err  <= 1'b0;
        underflow_err <= 1'b0;
      end else begin
        if (fifo_hw_wr && !push_ok) overflow_err  <= 1'b1;
        if (fifo_hw_rd && !pop_ok)  underflow_err <= 1'b1;
      end
    end
  end

  // ARMED looks at next-cycle emptiness so the grant rises right after the first push.
  always_comb begin
    ss_nxt = ss_q;
    unique case (ss_q)
      SS_IDLE:  if (ss_step) ss_nxt = fifo_empty ? SS_ARMED : SS_GRANT;
      SS_ARMED: if (!empty_nxt) ss_nxt = SS_GRANT;
      SS_GRANT: if (pop_ok) ss_nxt = SS_IDLE;
      default:  ss_nxt = SS_IDLE;
    endcase
    if (fifo_debug_mode != MODE_SS) ss_nxt = SS_IDLE;
  end

`ifdef CR_OSF_OB_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                  fifo_hwm <= '0;
    else if (stats_clr)          fifo_hwm <= fifo_used;
    else if (fifo_used > fifo_hwm) fifo_hwm <= fifo_used;
  end
`endif

endmodule
